// File: rtl/seg_word_decoder_pkg.sv
// Shared 7-segment character set and decoder FSM encoding.
// Char codes, active-low segment patterns [0:6]=a..g, state enum.
package seg_chars_pkg;

  typedef enum logic [2:0] {
    CH_BLANK = 3'd0,
    CH_O     = 3'd1,
    CH_I     = 3'd2,
    CH_E     = 3'd3,
    CH_D     = 3'd4,
    CH_BAD   = 3'd7
  } char_t;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_O     = 7'b0000001;
  localparam logic [0:6] SEG_I     = 7'b1001111;
  localparam logic [0:6] SEG_E     = 7'b0110000;
  localparam logic [0:6] SEG_D     = 7'b1000010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  localparam logic [2:0] CAND_INV = 3'd7;

endpackage

// File: rtl/seg_word_decoder_if.sv
// Display readback bus: HEX0..HEX5 in, word position/status out.
// master drives HEX and reads status; slave is the decoder.
interface seg_word_decoder_if #(
  parameter int CNT_W = 8
);
  logic [0:6]       HEX0;
  logic [0:6]       HEX1;
  logic [0:6]       HEX2;
  logic [0:6]       HEX3;
  logic [0:6]       HEX4;
  logic [0:6]       HEX5;
  logic [2:0]       pos;
  logic             pos_valid;
  logic             frame_err;
  logic             change_pulse;
  logic [CNT_W-1:0] change_cnt;
`ifdef SEG_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

  modport master (
    output HEX0, HEX1, HEX2,
    output HEX3, HEX4, HEX5,
    input  pos, pos_valid, frame_err,
    input  change_pulse, change_cnt
`ifdef SEG_ERR_CNT_EN
    , input err_cnt
`endif
  );

  modport slave (
    input  HEX0, HEX1, HEX2,
    input  HEX3, HEX4, HEX5,
    output pos, pos_valid, frame_err,
    output change_pulse, change_cnt
`ifdef SEG_ERR_CNT_EN
    , output err_cnt
`endif
  );
endinterface

// File: rtl/seg7_char_decode.sv
// Combinational 7-segment pattern to character code.
// seg: active-low a..g; ch: CH_* code, CH_BAD if unknown.
import seg_chars_pkg::*;

module seg7_char_decode (
  input  logic [0:6] seg,
  output char_t      ch
);

  always_comb begin
    ch = CH_BAD;
    unique case (1'b1)
      seg == SEG_BLANK: ch = CH_BLANK;
      seg == SEG_O:     ch = CH_O;
      seg == SEG_I:     ch = CH_I;
      seg == SEG_E:     ch = CH_E;
      seg == SEG_D:     ch = CH_D;
      default:          ch = CH_BAD;
    endcase
  end

endmodule

// File: rtl/seg_word_decoder.sv
// Locates the word "dE10" on six readback HEX digits (pos 0..5).
// Ports: CLOCK_50, reset (sync high), bus (slave); SEG_ERR_CNT_EN adds err_cnt.
import seg_chars_pkg::*;

module seg_word_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic                CLOCK_50,
  input logic                reset,
  seg_word_decoder_if.slave  bus
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STAB_ONE = SW'(1);

  logic [0:6]       hex_q [6];
  logic             smp_q;
  char_t            ch [6];
  logic [2:0]       cand;
  logic [2:0]       nmatch;
  logic [2:0]       cand_q;
  logic [SW-1:0]    stab_q;
  logic [SW-1:0]    stab_d;
  logic             chg;
  logic             qual;
  state_t           st_q;
  state_t           st_d;
  logic [2:0]       pos_q;
  logic [2:0]       pos_d;
  logic             pulse_q;
  logic             pulse_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // smp_q marks that hex_q holds a real sample, not the reset blank
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) hex_q[i] <= SEG_BLANK;
      smp_q <= 1'b0;
    end else begin
      hex_q[0] <= bus.HEX0;
      hex_q[1] <= bus.HEX1;
      hex_q[2] <= bus.HEX2;
      hex_q[3] <= bus.HEX3;
      hex_q[4] <= bus.HEX4;
      hex_q[5] <= bus.HEX5;
      smp_q    <= 1'b1;
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_dec
    seg7_char_decode u_dec (
      .seg (hex_q[g]),
      .ch  (ch[g])
    );
  end

  always_comb begin
    cand   = CAND_INV;
    nmatch = '0;
    for (int p = 0; p < 6; p++) begin
      if (ch[p] == CH_O &&
          ch[(p+1)%6] == CH_I &&
          ch[(p+2)%6] == CH_E &&
          ch[(p+3)%6] == CH_D &&
          ch[(p+4)%6] == CH_BLANK &&
          ch[(p+5)%6] == CH_BLANK) begin
        nmatch = nmatch + 3'd1;
        cand   = 3'(p);
      end
    end
    if (nmatch != 3'd1) cand = CAND_INV;
  end

  // Qualify once, on the edge the run length first hits the target;
  // a change always restarts the run, even at STABLE_CYCLES=1
  always_comb begin
    chg = (stab_q == '0) || (cand != cand_q);
    if (!smp_q)
      stab_d = '0;
    else if (chg)
      stab_d = STAB_ONE;
    else if (stab_q == STAB_MAX)
      stab_d = STAB_MAX;
    else
      stab_d = stab_q + STAB_ONE;
    qual = smp_q && (stab_d == STAB_MAX) &&
           (chg || (stab_q != STAB_MAX));
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cand_q <= CAND_INV;
      stab_q <= '0;
    end else begin
      cand_q <= cand;
      stab_q <= stab_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    pos_d   = pos_q;
    pulse_d = 1'b0;
    cnt_d   = cnt_q;
    if (qual) begin
      unique case (st_q)
        ST_IDLE: begin
          if (cand == CAND_INV) begin
            st_d = ST_FAULT;
          end else begin
            st_d  = ST_LOCKED;
            pos_d = cand;
          end
        end
        ST_LOCKED, ST_FAULT: begin
          if (cand == CAND_INV) begin
            st_d = ST_FAULT;
          end else begin
            st_d = ST_LOCKED;
            if (cand != pos_q) begin
              pos_d   = cand;
              pulse_d = 1'b1;
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      st_q    <= ST_IDLE;
      pos_q   <= '0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      pos_q   <= pos_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pos          = pos_q;
  assign bus.pos_valid    = (st_q == ST_LOCKED);
  assign bus.frame_err    = (st_q == ST_FAULT);
  assign bus.change_pulse = pulse_q;
  assign bus.change_cnt   = cnt_q;

`ifdef SEG_ERR_CNT_EN
  logic [CNT_W-1:0] err_q;
  logic             f_entry;

  assign f_entry = (st_d == ST_FAULT) &&
                   (st_q != ST_FAULT);

  always_ff @(posedge CLOCK_50) begin
    if (reset)
      err_q <= '0;
    else if (f_entry && (err_q != '1))
      err_q <= err_q + CNT_W'(1);
  end

  assign bus.err_cnt = err_q;
`endif

endmodule

// File: tb/tb_seg_word_decoder.sv
// Scoreboard bench for seg_word_decoder: random/directed HEX frames
// checked against a windowed behavioural model of the word locator.
module tb_seg_word_decoder;

  localparam int S = 4;
  localparam int W = 8;

  typedef struct {
    int pos;
    int pv;
    int fe;
    int cp;
    int cc;
    int ec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:6] hx [6];

  int   nvec = 0;
  int   nerr = 0;
  exp_t sb [$];

  int   hist [$];
  int   m_st = 0;
  int   m_pos = 0;
  int   m_cp = 0;
  int   m_cc = 0;
  int   m_ec = 0;

  always #10 clk = ~clk;

  seg_word_decoder_if #(.CNT_W(W)) bus ();

  assign bus.HEX0 = hx[0];
  assign bus.HEX1 = hx[1];
  assign bus.HEX2 = hx[2];
  assign bus.HEX3 = hx[3];
  assign bus.HEX4 = hx[4];
  assign bus.HEX5 = hx[5];

  seg_word_decoder #(
    .STABLE_CYCLES (S),
    .CNT_W         (W)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  function automatic byte chr(logic [0:6] s);
    case (s)
      7'b1111111: return " ";
      7'b0000001: return "O";
      7'b1001111: return "I";
      7'b0110000: return "E";
      7'b1000010: return "D";
      default:    return "?";
    endcase
  endfunction

  // Word position read left-to-right from HEX[p] upward: "OIED  "
  function automatic int frame_pos();
    string pat = "OIED  ";
    byte   c [6];
    int    n = 0;
    int    r = -1;
    bit    ok;
    for (int i = 0; i < 6; i++) c[i] = chr(hx[i]);
    for (int p = 0; p < 6; p++) begin
      ok = 1'b1;
      for (int k = 0; k < 6; k++)
        if (c[(p+k)%6] != pat[k]) ok = 1'b0;
      if (ok) begin
        n++;
        r = p;
      end
    end
    return (n == 1) ? r : -1;
  endfunction

  // Outputs after this edge: a capture run of exactly S equal
  // frames (preceded by a different one, or by reset) is acted on.
  task automatic model_edge();
    exp_t e;
    int   L;
    int   c;
    bit   q;
    if (rst) begin
      hist.delete();
      m_st  = 0;
      m_pos = 0;
      m_cp  = 0;
      m_cc  = 0;
      m_ec  = 0;
    end else begin
      m_cp = 0;
      L    = hist.size();
      q    = 1'b0;
      c    = -1;
      if (L >= S) begin
        c = hist[L-1];
        q = 1'b1;
        for (int k = L - S; k < L; k++)
          if (hist[k] != c) q = 1'b0;
        if (L > S && hist[L-S-1] == c) q = 1'b0;
      end
      if (q) begin
        if (c < 0) begin
          if (m_st != 2) begin
            m_st = 2;
            if (m_ec != (1 << W) - 1) m_ec++;
          end
        end else begin
          if (m_st != 0 && c != m_pos) begin
            m_cp = 1;
            m_cc = (m_cc + 1) % (1 << W);
          end
          m_st  = 1;
          m_pos = c;
        end
      end
      hist.push_back(frame_pos());
      if (hist.size() > S + 1) void'(hist.pop_front());
    end
    e.pos = m_pos;
    e.pv  = (m_st == 1) ? 1 : 0;
    e.fe  = (m_st == 2) ? 1 : 0;
    e.cp  = m_cp;
    e.cc  = m_cc;
    e.ec  = m_ec;
    sb.push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic set_word(int p);
    for (int i = 0; i < 6; i++) hx[i] = 7'b1111111;
    hx[p]       = 7'b0000001;
    hx[(p+1)%6] = 7'b1001111;
    hx[(p+2)%6] = 7'b0110000;
    hx[(p+3)%6] = 7'b1000010;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exv);
    nvec++;
    if (act !== exv) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exv, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pos", 32'(bus.pos), e.pos);
      chk("pos_valid", 32'(bus.pos_valid), e.pv);
      chk("frame_err", 32'(bus.frame_err), e.fe);
      chk("change_pulse", 32'(bus.change_pulse), e.cp);
      chk("change_cnt", 32'(bus.change_cnt), e.cc);
`ifdef SEG_ERR_CNT_EN
      chk("err_cnt", 32'(bus.err_cnt), e.ec);
`endif
    end
  end

  initial begin
    int a;
    int pick;
    for (int i = 0; i < 6; i++) hx[i] = 7'b1111111;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(7);
    set_word(0);
    tick(8);
    set_word(3);
    tick(8);
    hx[1] = 7'b0000000;
    tick(2);
    set_word(3);
    tick(8);
    hx[0] = 7'b0000000;
    tick(8);
    set_word(3);
    tick(8);
    set_word(0);
    tick(8);
    set_word(3);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(8);
    for (int it = 0; it < 400; it++) begin
      a = int'($urandom_range(0, 99));
      if (a < 3) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end else if (a < 55) begin
        set_word(int'($urandom_range(0, 5)));
        tick(int'($urandom_range(1, 7)));
      end else if (a < 80) begin
        pick = int'($urandom_range(0, 5));
        hx[pick] = 7'($urandom);
        tick(int'($urandom_range(1, 5)));
      end else begin
        for (int i = 0; i < 6; i++)
          hx[i] = ($urandom_range(0, 1) == 0) ?
                  7'b1111111 : 7'($urandom);
        tick(int'($urandom_range(1, 6)));
      end
    end
    for (int it = 0; it < 270; it++) begin
      set_word(it % 2 == 0 ? 1 : 4);
      tick(S + 1);
    end
    tick(2);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
